// File: rtl/seg_scan_mux_if.sv
// Display-side bundle between the scan driver and its control/decoder neighbours.
// Latency: n/a (wires only).
// Backpressure: none; every signal is a plain level or strobe.
interface seg_scan_mux_if;
  logic        enable;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  nibble;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  modport master (
    output enable, value_in, dp_in, load, blank_lz,
    input  nibble, dp, an, frame_done
  );

  modport slave (
    input  enable, value_in, dp_in, load, blank_lz,
    output nibble, dp, an, frame_done
  );
endinterface

// File: rtl/seg_scan_mux.sv
// 4-digit common-anode scan driver with frame-aligned double buffering, LZ blanking, dead time.
// Latency: outputs are registered, one cycle behind the cnt/idx state they depict.
// Backpressure: none; load is accepted every cycle, last load before a frame end wins.
module seg_scan_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYC    = 500
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_scan_mux_if.slave bus
);

  localparam int            CW   = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] TC   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DEAD = CW'(DEAD_CYC);

  typedef enum logic {IDLE, PENDING} st_t;

  st_t           st, st_nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   disp, shadow;
  logic [3:0]    dpreg, shadow_dp;
  logic          frame_end;
  logic          commit_en;
  logic [3:0]    nib_cur;
  logic [3:0]    blank_vec;
  logic          lit;

  // Last slot of the frame while scanning: the only point a new value may land.
  assign frame_end = bus.enable && (idx == 2'd3) && (cnt == TC);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  // Next state: frame end always drains the buffer; a load there commits straight through.
  always_comb begin
    st_nxt    = st;
    commit_en = 1'b0;
    if (frame_end) begin
      st_nxt    = IDLE;
      commit_en = bus.load || (st == PENDING);
    end else if (bus.load) begin
      st_nxt = PENDING;
    end
  end

  // Slot counter and digit index; held at digit 0 / cnt 0 while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (!bus.enable) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (cnt == TC) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow capture (also while disabled) and frame-aligned commit into the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      shadow_dp <= '0;
      disp      <= '0;
      dpreg     <= '0;
    end else begin
      if (bus.load) begin
        shadow    <= bus.value_in;
        shadow_dp <= bus.dp_in;
      end
      if (commit_en) begin
        disp  <= bus.load ? bus.value_in : shadow;
        dpreg <= bus.load ? bus.dp_in    : shadow_dp;
      end
    end
  end

  // Current digit, blanking (zero from here upward with no dp), and anode-active decision.
  always_comb begin
    nib_cur      = disp[{idx, 2'b00} +: 4];
    blank_vec    = 4'b0000;
    blank_vec[3] = bus.blank_lz && (disp[15:12] == 4'h0)  && !dpreg[3];
    blank_vec[2] = bus.blank_lz && (disp[15:8]  == 8'h00) && !dpreg[2];
    blank_vec[1] = bus.blank_lz && (disp[15:4]  == 12'h0) && !dpreg[1];
    lit          = bus.enable && (cnt >= DEAD) && !blank_vec[idx];
  end

  // Registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.an         <= 4'b1111;
      bus.nibble     <= 4'h0;
      bus.dp         <= 1'b1;
      bus.frame_done <= 1'b0;
    end else begin
      bus.an         <= lit ? ~(4'b0001 << idx) : 4'b1111;
      bus.dp         <= lit ? ~dpreg[idx] : 1'b1;
      bus.nibble     <= nib_cur;
      bus.frame_done <= frame_end;
    end
  end

endmodule
